// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between the I-cache fill path
// and the D-cache fill / write-through path with two-way round-robin.
// Fills issue WORDS consecutive reads and count returned words independently of
// issue, so any in-order read latency (including zero) is tolerated.
module mem_arbiter #(
  parameter int unsigned WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [15:0]                i_addr,
  output logic                       i_grant,
  output logic                       i_done,
  input  logic                       d_req,
  input  logic                       d_wr,
  input  logic [15:0]                d_addr,
  input  logic [15:0]                d_wdata,
  output logic                       d_grant,
  output logic                       d_done,
  output logic [15:0]                fill_data,
  output logic [$clog2(WORDS)-1:0]   fill_word,
  output logic                       fill_valid,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic [15:0]                mem_rdata,
  input  logic                       mem_rvalid
);

  localparam int unsigned WIDX = $clog2(WORDS);
  localparam int unsigned OFFB = WIDX + 1;
  localparam logic [15:0] BLK_MASK = ~16'((32'd1 << OFFB) - 32'd1);
  localparam logic [WIDX-1:0] LAST = WIDX'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [WIDX-1:0] iss, iss_nxt;
  logic [WIDX-1:0] ret, ret_nxt;
  logic            last_d, last_d_nxt;
  logic [15:0]     base, base_nxt;
  logic            i_grant_nxt, d_grant_nxt;
  logic            mem_en_nxt, mem_wr_nxt;
  logic [15:0]     mem_addr_nxt, mem_wdata_nxt;
  logic            in_fill;
  logic            last_ret;

  // Returned data passes straight through; validity is qualified by state.
  assign fill_data = mem_rdata;
  assign fill_word = ret;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_nxt     = state;
    iss_nxt       = iss;
    ret_nxt       = ret;
    last_d_nxt    = last_d;
    base_nxt      = base;
    i_grant_nxt   = 1'b0;
    d_grant_nxt   = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_wr_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    fill_valid    = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    in_fill       = 1'b0;
    last_ret      = 1'b0;

    case (state)
      IDLE: begin
        iss_nxt = '0;
        ret_nxt = '0;
        // D wins when it is alone or when I was served most recently.
        if (d_req && (!i_req || !last_d)) begin
          last_d_nxt  = 1'b1;
          d_grant_nxt = 1'b1;
          mem_en_nxt  = 1'b1;
          if (d_wr) begin
            state_nxt     = WRITE;
            mem_wr_nxt    = 1'b1;
            mem_addr_nxt  = {d_addr[15:1], 1'b0};
            mem_wdata_nxt = d_wdata;
          end else begin
            state_nxt    = FILL_D;
            base_nxt     = d_addr & BLK_MASK;
            mem_addr_nxt = d_addr & BLK_MASK;
          end
        end else if (i_req) begin
          last_d_nxt   = 1'b0;
          i_grant_nxt  = 1'b1;
          mem_en_nxt   = 1'b1;
          state_nxt    = FILL_I;
          base_nxt     = i_addr & BLK_MASK;
          mem_addr_nxt = i_addr & BLK_MASK;
        end
      end

      FILL_I, FILL_D: begin
        in_fill     = 1'b1;
        i_grant_nxt = (state == FILL_I);
        d_grant_nxt = (state == FILL_D);
        // Issue side: one read per cycle until WORDS have gone out.
        if (mem_en && (iss != LAST)) begin
          iss_nxt      = iss + WIDX'(1);
          mem_en_nxt   = 1'b1;
          mem_addr_nxt = base + 16'({iss_nxt, 1'b0});
        end
        // Return side: count words as they arrive, in issue order.
        if (mem_rvalid) begin
          fill_valid = 1'b1;
          ret_nxt    = ret + WIDX'(1);
          last_ret   = (ret == LAST);
        end
        if (last_ret) begin
          i_done      = (state == FILL_I);
          d_done      = (state == FILL_D);
          state_nxt   = IDLE;
          i_grant_nxt = 1'b0;
          d_grant_nxt = 1'b0;
          mem_en_nxt  = 1'b0;
          iss_nxt     = '0;
          ret_nxt     = '0;
        end
      end

      WRITE: begin
        // Single write cycle: strobe is already on the port, finish now.
        d_done    = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      iss       <= '0;
      ret       <= '0;
      last_d    <= 1'b0;
      base      <= '0;
      i_grant   <= 1'b0;
      d_grant   <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      iss       <= iss_nxt;
      ret       <= ret_nxt;
      last_d    <= last_d_nxt;
      base      <= base_nxt;
      i_grant   <= i_grant_nxt;
      d_grant   <= d_grant_nxt;
      mem_en    <= mem_en_nxt;
      mem_wr    <= mem_wr_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized checks of mem_arbiter against a
// transaction-level reference model and an in-order variable-latency memory.
module tb_mem_arbiter;

  localparam int WORDS  = 8;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_WR   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_done, d_grant, d_done;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_valid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;

  mem_arbiter #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_done(d_done),
    .fill_data(fill_data), .fill_word(fill_word), .fill_valid(fill_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } rd_t;

  logic [15:0] mem [0:32767];
  rd_t         rq[$];
  int          obs_srv[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  int          lat = 0;
  int          gaps = 0;
  // Transaction-level model state
  int          mode = M_IDLE;
  bit          cur_d, last_d, fin;
  logic [15:0] cur_base, cur_waddr, cur_wdata;
  int          n_iss, n_ret, n_srv, grant_cyc, done_cyc;
  bit          prev_ig, prev_dg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string t);
    chk({t, "_i_grant"}, i_grant, 0);
    chk({t, "_d_grant"}, d_grant, 0);
    chk({t, "_i_done"}, i_done, 0);
    chk({t, "_d_done"}, d_done, 0);
    chk({t, "_mem_en"}, mem_en, 0);
    chk({t, "_mem_wr"}, mem_wr, 0);
    chk({t, "_fill_valid"}, fill_valid, 0);
    chk({t, "_fill_word"}, fill_word, 0);
  endtask

  // One clock cycle: predict grant, advance the memory, compare every output.
  task automatic cyc();
    int          go;
    bit          wr, rv, fm, ev, lst;
    logic [15:0] a_i, a_d, wd, ra;
    go = 0;
    if (mode == M_IDLE && !rst) begin
      if (d_req && (!i_req || !last_d)) go = 2;
      else if (i_req) go = 1;
    end
    a_i = i_addr; a_d = d_addr; wd = d_wdata; wr = d_wr;
    @(posedge clk); #1;
    cyc_n++;
    if (rst) mode = M_IDLE;
    else if (go != 0) begin
      n_srv++;
      cur_d = (go == 2);
      last_d = cur_d;
      n_iss = 0; n_ret = 0; grant_cyc = cyc_n;
      if (cur_d && wr) begin
        mode = M_WR; cur_waddr = a_d & 16'hFFFE; cur_wdata = wd;
      end else begin
        mode = M_FILL;
        cur_base = (cur_d ? a_d : a_i) & ~16'(2 * WORDS - 1);
      end
    end else if (mode == M_WR || fin) mode = M_IDLE;
    fin = 0;
    if (d_grant && !prev_dg) obs_srv.push_back(1);
    if (i_grant && !prev_ig) obs_srv.push_back(0);
    prev_dg = d_grant; prev_ig = i_grant;
    // In-order memory: accept reads, return after lat cycles, optional gaps.
    if (mem_en === 1'b1 && mem_wr === 1'b0) rq.push_back('{mem_addr, cyc_n + lat});
    rv = 0; ra = 16'h0;
    if (rq.size() > 0 && rq[0].due <= cyc_n && !(gaps != 0 && $urandom_range(0, 2) == 0)) begin
      rv = 1; ra = rq[0].addr; void'(rq.pop_front());
    end
    mem_rvalid = rv;
    mem_rdata  = rv ? mem[ra[15:1]] : 16'($urandom);
    #1;
    fm = (mode == M_FILL);
    chk("i_grant", i_grant, fm && !cur_d);
    chk("d_grant", d_grant, mode != M_IDLE && cur_d);
    chk("mem_en", mem_en, (fm && n_iss < WORDS) || mode == M_WR);
    chk("mem_wr", mem_wr, mode == M_WR);
    if (fm && n_iss < WORDS) begin
      chk("issue_addr", mem_addr, cur_base + 16'(2 * n_iss));
      n_iss++;
    end
    if (mode == M_WR) begin
      chk("wr_addr", mem_addr, cur_waddr);
      chk("wr_data", mem_wdata, cur_wdata);
    end
    ev  = fm && rv;
    lst = ev && (n_ret == WORDS - 1);
    chk("fill_valid", fill_valid, ev);
    chk("fill_word", fill_word, fm ? n_ret : 0);
    if (ev) chk("fill_data", fill_data, mem[ra[15:1]]);
    chk("i_done", i_done, lst && !cur_d);
    chk("d_done", d_done, (lst && cur_d) || mode == M_WR);
    if (ev) n_ret++;
    if (lst || mode == M_WR) begin
      fin = 1; done_cyc = cyc_n;
    end
  endtask

  task automatic run_txn(input string tag);
    int k = 0;
    do begin cyc(); k++; end while (!fin && k < 300);
    chk({tag, "_complete"}, fin, 1);
  endtask

  task automatic drop_all();
    i_req = 0; d_req = 0; d_wr = 0;
    cyc();
  endtask

  initial begin
    int k, s0;
    int exp_ord[4];
    exp_ord = '{1, 0, 1, 0};
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    rst = 1; i_req = 1; d_req = 1; d_wr = 0;
    i_addr = 16'h0100; d_addr = 16'h0200; d_wdata = 16'h0;
    mem_rvalid = 0; mem_rdata = 0;
    #1;
    chk_reset_outputs("reset");
    lat = 2;
    cyc(); cyc(); cyc();
    chk_reset_outputs("reset_held");
    rst = 0;

    // Contention from reset: D first, then alternate, one IDLE between.
    s0 = obs_srv.size(); n_srv = 0; k = 0;
    while (!(n_srv >= 4 && fin) && k < 300) begin cyc(); k++; end
    chk("contend_fill_count", obs_srv.size() - s0 >= 4, 1);
    if (obs_srv.size() - s0 >= 4)
      for (int i = 0; i < 4; i++) chk("contend_fill_order", obs_srv[s0 + i], exp_ord[i]);
    drop_all();

    // D write contending with I alternates the same way.
    i_req = 1; d_req = 1; d_wr = 1; d_wdata = 16'h5A5A;
    s0 = obs_srv.size(); n_srv = 0; k = 0;
    while (!(n_srv >= 4 && fin) && k < 300) begin cyc(); k++; end
    chk("contend_wr_count", obs_srv.size() - s0 >= 4, 1);
    if (obs_srv.size() - s0 >= 4)
      for (int i = 0; i < 4; i++) chk("contend_wr_order", obs_srv[s0 + i], exp_ord[i]);
    drop_all();

    // Single D write.
    d_req = 1; d_wr = 1; d_addr = 16'h0045; d_wdata = 16'hBEEF;
    run_txn("d_write");
    drop_all();

    // I fill at latency 4.
    lat = 4; gaps = 0;
    i_req = 1; i_addr = 16'h1236;
    run_txn("i_fill");
    chk("i_fill_done_time", done_cyc - grant_cyc, WORDS - 1 + 4);
    drop_all();

    // Abort after three returned words; memory keeps responding.
    lat = 1;
    i_req = 1; i_addr = 16'h1500;
    k = 0;
    while (n_ret < 3 && k < 100) begin cyc(); k++; end
    chk("abort_reached", n_ret >= 3, 1);
    rst = 1; i_req = 0;
    #1;
    chk_reset_outputs("abort");
    mode = M_IDLE; last_d = 0; fin = 0;
    for (int i = 0; i < 6; i++) cyc();
    rst = 0;
    rq.delete();
    cyc();
    i_req = 1; i_addr = 16'h2000;
    run_txn("post_abort_fill");
    drop_all();

    // Zero latency D fill.
    lat = 0; gaps = 0;
    d_req = 1; d_wr = 0; d_addr = 16'($urandom);
    run_txn("d_fill_l0");
    chk("d_fill_l0_done_time", done_cyc - grant_cyc, WORDS - 1);
    drop_all();

    // Latency 1 with random return gaps.
    lat = 1; gaps = 1;
    i_req = 1; i_addr = 16'($urandom);
    run_txn("i_fill_gaps");
    drop_all();

    // Randomized single-requester transactions.
    for (int t = 0; t < 8; t++) begin
      lat = $urandom_range(0, 3); gaps = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        d_req = 1; d_wr = ($urandom_range(0, 3) == 0);
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end else begin
        i_req = 1; i_addr = 16'($urandom);
      end
      run_txn("random_txn");
      drop_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
